calc_sequencer: RTL and testbench

CALC_SEQUENCER -- requirements
Module: calc_sequencer

---
 rtl/calc_pkg.sv | 30 +++
 rtl/calc_sequencer_settle.sv | 49 ++++
 rtl/calc_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_calc_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared encodings for the calculator sequencer.
// Holds the FSM state encoding, the op-codes that need divide-by-zero
// protection, the flag bit positions and the settle-counter width.
package calc_pkg;

  // FSM state encoding (legacy-compatible constants)
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  // Op-codes whose second operand must be non-zero
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_MOD = 4'b0100;

  // Flag bit positions, shared by alu_flags and rsp_flags
  localparam int unsigned FLAG_CARRY  = 32'd0;
  localparam int unsigned FLAG_OVF    = 32'd1;
  localparam int unsigned FLAG_BORROW = 32'd2;
  localparam int unsigned FLAG_DIV0   = 32'd3;

  // Settle counter width; covers the full SETTLE range 1..15
  localparam int unsigned CNT_W = 32'd4;

  // True for the operations that divide by operand 2
  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/calc_sequencer_settle.sv
// settle_counter: down-counter that times the ALU settle window.
// load has priority over dec; the count saturates at zero. terminal is
// registered and is high exactly while the count equals one.
module settle_counter
  import calc_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         terminal
);

  localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};

  logic [W-1:0] count_r;
  logic [W-1:0] count_nxt_s;
  logic         terminal_r;

  // next count: load wins, otherwise decrement without wrapping below zero
  always_comb begin
    count_nxt_s = count_r;
    if (load) begin
      count_nxt_s = load_val;
    end else if (dec && (count_r != CNT_ZERO)) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // count register with its terminal flag registered alongside
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r    <= CNT_ZERO;
      terminal_r <= 1'b0;
    end else begin
      count_r    <= count_nxt_s;
      terminal_r <= (count_nxt_s == CNT_ONE);
    end
  end

  assign terminal = terminal_r;

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: issues one command at a time to an external ALU, waits
// SETTLE cycles for the result, then holds it as a response until consumed.
// Divide/modulo by zero is trapped here: result forced to 0, flag bit 3 set.
// Optional feature macro: CALC_ACCUM_EN adds an N-bit accumulator that can
// replace operand 1 (selected by cmd_acc); without it cmd_acc is ignored.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int N      = 4,
  parameter int SETTLE = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [3:0]     cmd_op,
  input  logic [N-1:0]   cmd_a,
  input  logic [N-1:0]   cmd_b,
  input  logic           cmd_acc,
  output logic [3:0]     alu_op,
  output logic [N-1:0]   alu_a,
  output logic [N-1:0]   alu_b,
  input  logic [2*N-1:0] alu_result,
  input  logic [3:0]     alu_flags,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [2*N-1:0] rsp_result,
  output logic [3:0]     rsp_flags,
  output logic           rsp_zero,
  output logic           busy
);

  localparam logic [CNT_W-1:0] SETTLE_L = CNT_W'(SETTLE);
  localparam logic [N-1:0]     OPND_Z   = {N{1'b0}};
  localparam logic [2*N-1:0]   RES_Z    = {(2*N){1'b0}};

  // FSM and handshake
  state_t         state_r;
  state_t         state_nxt_s;
  logic           cmd_ready_r;
  logic           busy_r;
  logic           cmd_hs_s;
  logic           capture_s;
  logic           settle_done_s;

  // ALU-facing operand registers
  logic [3:0]     alu_op_r;
  logic [N-1:0]   alu_a_r;
  logic [N-1:0]   alu_b_r;
  logic [N-1:0]   op1_s;

  // Response path
  logic           rsp_valid_r;
  logic [2*N-1:0] rsp_result_r;
  logic [3:0]     rsp_flags_r;
  logic           rsp_zero_r;
  logic [2*N-1:0] cap_result_s;
  logic [3:0]     cap_flags_s;
  logic           div0_s;

  // Inputs deliberately left without a consumer in some builds
  logic           unused_s;

  assign cmd_hs_s  = cmd_valid && (state_r == ST_IDLE);
  assign capture_s = (state_r == ST_WAIT) && settle_done_s;

  // Settle timer: loaded with SETTLE on a handshake, counts down in WAIT
  settle_counter #(
    .W (CNT_W)
  ) u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (cmd_hs_s),
    .load_val (SETTLE_L),
    .dec      (state_r == ST_WAIT),
    .terminal (settle_done_s)
  );

`ifdef CALC_ACCUM_EN
  logic [N-1:0] acc_r;

  // accumulator follows the low half of every consumed response
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r <= OPND_Z;
    end else if ((state_r == ST_RESP) && rsp_ready) begin
      acc_r <= rsp_result_r[N-1:0];
    end else begin
      acc_r <= acc_r;
    end
  end

  assign op1_s    = cmd_acc ? acc_r : cmd_a;
  assign unused_s = alu_flags[FLAG_DIV0];
`else
  assign op1_s    = cmd_a;
  assign unused_s = ^{cmd_acc, alu_flags[FLAG_DIV0]};
`endif

  // next-state decode; commands offered outside IDLE have no effect
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_hs_s) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (settle_done_s) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // state register plus status outputs registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cmd_ready_r <= (state_nxt_s == ST_IDLE);
      busy_r      <= (state_nxt_s != ST_IDLE);
      rsp_valid_r <= (state_nxt_s == ST_RESP);
    end
  end

  // operand registers: loaded on a handshake, held until the next one
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_op_r <= 4'b0000;
      alu_a_r  <= OPND_Z;
      alu_b_r  <= OPND_Z;
    end else if (cmd_hs_s) begin
      alu_op_r <= cmd_op;
      alu_a_r  <= op1_s;
      alu_b_r  <= cmd_b;
    end else begin
      alu_op_r <= alu_op_r;
      alu_a_r  <= alu_a_r;
      alu_b_r  <= alu_b_r;
    end
  end

  assign div0_s = is_div_op(alu_op_r) && (alu_b_r == OPND_Z);

  // value to capture: divide-by-zero overrides whatever the ALU reports
  always_comb begin
    cap_result_s = alu_result;
    cap_flags_s  = 4'b0000;
    if (div0_s) begin
      cap_result_s           = RES_Z;
      cap_flags_s            = 4'b0000;
      cap_flags_s[FLAG_DIV0] = 1'b1;
    end else begin
      cap_result_s             = alu_result;
      cap_flags_s              = 4'b0000;
      cap_flags_s[FLAG_CARRY]  = alu_flags[FLAG_CARRY];
      cap_flags_s[FLAG_OVF]    = alu_flags[FLAG_OVF];
      cap_flags_s[FLAG_BORROW] = alu_flags[FLAG_BORROW];
    end
  end

  // response registers: written only at the end of the settle window
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_result_r <= RES_Z;
      rsp_flags_r  <= 4'b0000;
      rsp_zero_r   <= 1'b1;
    end else if (capture_s) begin
      rsp_result_r <= cap_result_s;
      rsp_flags_r  <= cap_flags_s;
      rsp_zero_r   <= (cap_result_s == RES_Z);
    end else begin
      rsp_result_r <= rsp_result_r;
      rsp_flags_r  <= rsp_flags_r;
      rsp_zero_r   <= rsp_zero_r;
    end
  end

  assign cmd_ready  = cmd_ready_r;
  assign busy       = busy_r;
  assign alu_op     = alu_op_r;
  assign alu_a      = alu_a_r;
  assign alu_b      = alu_b_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_result = rsp_result_r;
  assign rsp_flags  = rsp_flags_r;
  assign rsp_zero   = rsp_zero_r;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: table-driven bench with a scoreboard for calc_sequencer.
// Expected responses are queued at each command handshake and compared when
// the response is consumed. A small behavioural ALU drives alu_result/flags.
module tb_calc_sequencer;

  localparam int N      = 4;
  localparam int SETTLE = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [3:0]     cmd_op = 4'h0;
  logic [N-1:0]   cmd_a = 4'h0;
  logic [N-1:0]   cmd_b = 4'h0;
  logic           cmd_acc = 1'b0;
  logic [3:0]     alu_op;
  logic [N-1:0]   alu_a;
  logic [N-1:0]   alu_b;
  logic [2*N-1:0] alu_result;
  logic [3:0]     alu_flags;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [2*N-1:0] rsp_result;
  logic [3:0]     rsp_flags;
  logic           rsp_zero;
  logic           busy;

  calc_sequencer #(.N(N), .SETTLE(SETTLE)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_acc    (cmd_acc),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .rsp_zero   (rsp_zero),
    .busy       (busy)
  );

  initial forever #5 clk = ~clk;

  // Behavioural ALU: add, mul, sub, div, mod; junk on div-by-zero and
  // flag bit 3 on unknown ops so the sequencer's masking is exercised.
  logic [7:0] ea, eb;
  always_comb begin
    ea = {4'h0, alu_a};
    eb = {4'h0, alu_b};
    alu_result = 8'h00;
    alu_flags  = 4'b0000;
    case (alu_op)
      4'h0: begin alu_result = ea + eb; alu_flags[0] = alu_result[4]; end
      4'h1: begin alu_result = ea * eb; alu_flags[1] = (alu_result > 8'd15); end
      4'h2: begin alu_result = {4'h0, alu_a - alu_b}; alu_flags[2] = (alu_a < alu_b); end
      4'h3: begin
        if (alu_b == 4'h0) begin alu_result = 8'hFF; alu_flags = 4'b0111; end
        else alu_result = ea / eb;
      end
      4'h4: begin
        if (alu_b == 4'h0) begin alu_result = 8'hFF; alu_flags = 4'b0111; end
        else alu_result = ea % eb;
      end
      default: begin alu_result = 8'h00; alu_flags = 4'b1000; end
    endcase
  end

  typedef struct {
    logic [3:0] op; logic [3:0] a; logic [3:0] b;
    logic [7:0] res; logic [3:0] flg; logic zero;
  } vec_t;

  typedef struct {
    logic [7:0] res; logic [3:0] flg; logic zero; int hs_edge;
  } exp_t;

  vec_t vecs[10];
  exp_t sb_q[$];
  exp_t cur_exp;
  int   hs_log[$];
  int   edges = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever @(posedge clk) edges++;

  // Scoreboard monitor: push on command handshake, compare on response handshake
  initial begin
    exp_t e;
    logic rv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb_q.delete();
        rv_prev = 1'b0;
      end else begin
        if (cmd_valid && cmd_ready) begin
          e = cur_exp;
          e.hs_edge = edges + 1;
          sb_q.push_back(e);
          hs_log.push_back(edges + 1);
        end
        if (rsp_valid && !rv_prev) begin
          check("rsp_expected", sb_q.size(), 1);
          if (sb_q.size() > 0) check("latency", edges - sb_q[0].hs_edge, SETTLE);
        end
        if (rsp_valid && rsp_ready && sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("rsp_result", rsp_result, e.res);
          check("rsp_flags", rsp_flags, e.flg);
          check("rsp_zero", rsp_zero, e.zero);
        end
        rv_prev = rsp_valid;
      end
    end
  end

  // Offer a command (called just after a rising edge) and wait for its handshake
  task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic acc, input logic [7:0] res, input logic [3:0] flg,
                       input logic zero);
    bit done = 1'b0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_acc = acc;
    cur_exp.res = res; cur_exp.flg = flg; cur_exp.zero = zero; cur_exp.hs_edge = 0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (cmd_ready) done = 1'b1;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_acc = 1'b0;
    check("issue_handshake", done, 1);
  endtask

  // Wait for all expected responses to be consumed and the DUT to be idle
  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && cmd_ready && !rsp_valid) done = 1'b1;
    end
    check("drain", done, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    bit saw_rsp;
    bit done;
    vecs[0] = '{4'h0, 4'h5, 4'h3, 8'h08, 4'b0000, 1'b0};
    vecs[1] = '{4'h0, 4'h9, 4'h9, 8'h12, 4'b0001, 1'b0};
    vecs[2] = '{4'h2, 4'h3, 4'h5, 8'h0E, 4'b0100, 1'b0};
    vecs[3] = '{4'h2, 4'h7, 4'h7, 8'h00, 4'b0000, 1'b1};
    vecs[4] = '{4'h3, 4'h9, 4'h0, 8'h00, 4'b1000, 1'b1};
    vecs[5] = '{4'h4, 4'h5, 4'h0, 8'h00, 4'b1000, 1'b1};
    vecs[6] = '{4'h3, 4'h9, 4'h2, 8'h04, 4'b0000, 1'b0};
    vecs[7] = '{4'h4, 4'h9, 4'h4, 8'h01, 4'b0000, 1'b0};
    vecs[8] = '{4'h1, 4'hF, 4'hF, 8'hE1, 4'b0010, 1'b0};
    vecs[9] = '{4'hF, 4'h6, 4'h6, 8'h00, 4'b0000, 1'b1};

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_flags", rsp_flags, 0);
    check("rst_rsp_zero", rsp_zero, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // table of single commands, consumer always ready
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, vecs[i].res, vecs[i].flg, vecs[i].zero);
      @(negedge clk);
      check("busy_in_wait", busy, 1);
      check("ready_in_wait", cmd_ready, 0);
      @(posedge clk); #1;
      wait_drain();
    end

    // backpressure: response held stable, new commands ignored
    rsp_ready = 1'b0;
    issue(4'h1, 4'h2, 4'h7, 1'b0, 8'h0E, 4'b0000, 1'b0);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (rsp_valid) done = 1'b1;
    end
    check("bp_rsp_seen", done, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_op = 4'h0; cmd_a = 4'hA; cmd_b = 4'h1;
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_result", rsp_result, 8'h0E);
      check("bp_rsp_flags", rsp_flags, 4'b0000);
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_alu_a", alu_a, 4'h2);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_idle_ready", cmd_ready, 1);
    check("bp_idle_valid", rsp_valid, 0);
    check("bp_idle_busy", busy, 0);
    check("hold_alu_op", alu_op, 4'h1);
    check("hold_alu_a", alu_a, 4'h2);
    check("hold_alu_b", alu_b, 4'h7);
    check("bp_sb_empty", sb_q.size(), 0);
    @(posedge clk); #1;

    // throughput with cmd_valid and rsp_ready held high
    hs_log.delete();
    cmd_op = 4'h0; cmd_a = 4'h1; cmd_b = 4'h1; cmd_acc = 1'b0;
    cur_exp.res = 8'h02; cur_exp.flg = 4'b0000; cur_exp.zero = 1'b0; cur_exp.hs_edge = 0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 40 && hs_log.size() < 2; i++) @(negedge clk);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("tput_hs_count", hs_log.size(), 2);
    if (hs_log.size() >= 2) check("tput_gap", hs_log[1] - hs_log[0], SETTLE + 2);
    wait_drain();

    // reset one cycle after handshake discards the command
    issue(4'h0, 4'h5, 4'h3, 1'b0, 8'h08, 4'b0000, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("wrst_cmd_ready", cmd_ready, 1);
    check("wrst_rsp_valid", rsp_valid, 0);
    check("wrst_alu_a", alu_a, 0);
    check("wrst_busy", busy, 0);
    saw_rsp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1'b1;
    end
    check("wrst_no_rsp", saw_rsp, 0);
    @(posedge clk); #1;

`ifdef CALC_ACCUM_EN
    // accumulator: 3+4, then acc+2
    issue(4'h0, 4'h3, 4'h4, 1'b0, 8'h07, 4'b0000, 1'b0);
    wait_drain();
    issue(4'h0, 4'hF, 4'h2, 1'b1, 8'h09, 4'b0000, 1'b0);
    wait_drain();
`else
    // cmd_acc has no effect without the accumulator
    issue(4'h0, 4'h1, 4'h2, 1'b1, 8'h03, 4'b0000, 1'b0);
    wait_drain();
`endif

    check("final_sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
